// File: rtl/radix4_booth_mult_seq_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier.
package radix4_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FINISH
    } state_t;

    typedef enum logic [2:0] {
        ZERO,
        POS1,
        POS2,
        NEG1,
        NEG2
    } booth_digit_t;

    // One Booth digit per bit pair of the (width+2)-bit extended multiplier.
    function automatic int calc_n_iter(input int width);
        return width / 2 + 1;
    endfunction

    function automatic booth_digit_t booth_recode(input logic [2:0] window);
        case (window)
            3'b001, 3'b010: return POS1;
            3'b011:         return POS2;
            3'b100:         return NEG2;
            3'b101, 3'b110: return NEG1;
            default:        return ZERO;
        endcase
    endfunction

endpackage

// File: rtl/radix4_booth_mult_seq_if.sv
// Request/response bundle between the ALU issue logic and the Booth multiplier.
interface radix4_booth_mult_seq_if #(
    parameter int WIDTH = 32
);
    // start is sampled only while the multiplier is idle (or in its done cycle);
    // busy is high for every iteration cycle; done pulses once with product valid.
    logic                   start;
    logic                   signed_mode;
    logic [WIDTH-1:0]       in_m;
    logic [WIDTH-1:0]       in_q;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start, signed_mode, in_m, in_q,
        input  busy, done, product
    );

    modport slave (
        input  start, signed_mode, in_m, in_q,
        output busy, done, product
    );

endinterface

// File: rtl/radix4_booth_mult_seq_booth_digit_sel.sv
// Radix-4 Booth recoder: maps a 3-bit multiplier window to 0, +-M or +-2M.
module booth_digit_sel
    import radix4_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       window,
    input  logic [WIDTH+1:0] ext_m,
    output logic [WIDTH+2:0] multiple
);

    logic [WIDTH+2:0] m1;
    logic [WIDTH+2:0] m2;

    // One guard bit keeps 2M representable for the most negative extended M.
    assign m1 = {ext_m[WIDTH+1], ext_m};
    assign m2 = {ext_m, 1'b0};

    always_comb begin
        multiple = '0;
        case (booth_recode(window))
            POS1:    multiple = m1;
            POS2:    multiple = m2;
            NEG1:    multiple = -m1;
            NEG2:    multiple = -m2;
            default: multiple = '0;
        endcase
    end

endmodule

// File: rtl/radix4_booth_mult_seq.sv
// Sequential radix-4 Booth multiplier, signed or unsigned, one digit per cycle.
// Define RADIX4_ZERO_BYPASS_EN to finish zero-operand multiplies in one cycle.
module radix4_booth_mult_seq
    import radix4_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    radix4_booth_mult_seq_if.slave         bus,
    output state_t                         state_dbg
);

    localparam int N_ITER = calc_n_iter(WIDTH);
    localparam int CW     = $clog2(N_ITER);
    localparam int AW     = WIDTH + 3;
    localparam int QW     = WIDTH + 2;
    localparam int TW     = AW + QW + 1;

    state_t              state;
    logic [AW-1:0]       acc_a;
    logic [QW-1:0]       acc_q;
    logic                acc_qm1;
    logic [QW-1:0]       m_ext;
    logic [CW-1:0]       cnt;
    logic                busy_r;
    logic                done_r;
    logic [2*WIDTH-1:0]  product_r;

    logic [QW-1:0]       ext_m_in;
    logic [QW-1:0]       ext_q_in;
    logic [AW-1:0]       multiple;
    logic [AW-1:0]       sum;
    logic [TW-1:0]       shifted;
    logic                bypass;

    assign ext_m_in = bus.signed_mode ? {{2{bus.in_m[WIDTH-1]}}, bus.in_m} : {2'b00, bus.in_m};
    assign ext_q_in = bus.signed_mode ? {{2{bus.in_q[WIDTH-1]}}, bus.in_q} : {2'b00, bus.in_q};

`ifdef RADIX4_ZERO_BYPASS_EN
    assign bypass = (bus.in_m == '0) || (bus.in_q == '0);
`else
    assign bypass = 1'b0;
`endif

    booth_digit_sel #(.WIDTH(WIDTH)) u_sel (
        .window   ({acc_q[1:0], acc_qm1}),
        .ext_m    (m_ext),
        .multiple (multiple)
    );

    assign sum     = acc_a + multiple;
    assign shifted = TW'($signed({sum, acc_q, acc_qm1}) >>> 2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            acc_a     <= '0;
            acc_q     <= '0;
            acc_qm1   <= 1'b0;
            m_ext     <= '0;
            cnt       <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            product_r <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                // The done cycle accepts a new start exactly like IDLE does.
                IDLE, FINISH: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                    if (bus.start && bypass) begin
                        state     <= FINISH;
                        done_r    <= 1'b1;
                        product_r <= '0;
                    end else if (bus.start) begin
                        state   <= CALC;
                        busy_r  <= 1'b1;
                        m_ext   <= ext_m_in;
                        acc_a   <= '0;
                        acc_q   <= ext_q_in;
                        acc_qm1 <= 1'b0;
                        cnt     <= CW'(N_ITER - 1);
                    end
                end
                CALC: begin
                    acc_a   <= shifted[TW-1 -: AW];
                    acc_q   <= shifted[QW:1];
                    acc_qm1 <= shifted[0];
                    cnt     <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state     <= FINISH;
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                        product_r <= shifted[2*WIDTH:1];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.product = product_r;
    assign state_dbg   = state;

endmodule

// File: tb/tb_radix4_booth_mult_seq.sv
// Bench for radix4_booth_mult_seq: vector table, handshake corner cases, random vs arithmetic model.
module tb_radix4_booth_mult_seq;
    import radix4_pkg::*;

    localparam int W       = 32;
    localparam int N_ITER  = W / 2 + 1;
    localparam int TIMEOUT = 60;
`ifdef RADIX4_ZERO_BYPASS_EN
    localparam bit ZERO_BYP = 1'b1;
`else
    localparam bit ZERO_BYP = 1'b0;
`endif

    typedef struct {
        logic           sm;
        logic [W-1:0]   m;
        logic [W-1:0]   q;
        logic [2*W-1:0] exp;
    } vec_t;

    logic   clk;
    logic   reset;
    state_t state_dbg;
    int     n_cmp;
    int     n_bad;
    logic [2*W-1:0] exp_q[$];
    vec_t   vecs[10];

    radix4_booth_mult_seq_if #(.WIDTH(W)) bus ();

    radix4_booth_mult_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

    function automatic logic [2*W-1:0] ref_mult(input logic sm, input logic [W-1:0] m, input logic [W-1:0] q);
        longint a;
        longint b;
        logic [2*W-1:0] ua;
        logic [2*W-1:0] ub;
        if (sm) begin
            a = longint'($signed(m));
            b = longint'($signed(q));
            return 64'(a * b);
        end
        ua = {32'b0, m};
        ub = {32'b0, q};
        return ua * ub;
    endfunction

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return 32'(($urandom_range(0, 15)));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic run_op(input logic sm, input logic [W-1:0] m, input logic [W-1:0] q,
                          input logic [2*W-1:0] exp, input int restart_at, input string name);
        int j;
        int busy_high;
        int exp_lat;
        exp_q.push_back(exp);
        exp_lat = N_ITER + 1;
        if (ZERO_BYP && (m == '0 || q == '0)) exp_lat = 1;
        bus.start       = 1'b1;
        bus.signed_mode = sm;
        bus.in_m        = m;
        bus.in_q        = q;
        @(negedge clk);
        j         = 1;
        busy_high = 0;
        bus.start = 1'b0;
        while (!bus.done && j < TIMEOUT) begin
            if (bus.busy) busy_high++;
            bus.start       = (j == restart_at);
            bus.in_m        = $urandom;
            bus.in_q        = $urandom;
            bus.signed_mode = 1'($urandom_range(0, 1));
            @(negedge clk);
            j++;
        end
        bus.start = 1'b0;
        check({name, " latency"}, 64'(j), 64'(exp_lat));
        check({name, " busy cycles"}, 64'(busy_high), 64'(exp_lat - 1));
        check({name, " busy at done"}, 64'(bus.busy), 64'd0);
        check({name, " product"}, bus.product, exp_q.pop_front());
    endtask

    task automatic check_quiet(input int n, input string name, input logic [2*W-1:0] exp_prod);
        int dones;
        int busies;
        dones  = 0;
        busies = 0;
        repeat (n) begin
            @(negedge clk);
            if (bus.done) dones++;
            if (bus.busy) busies++;
        end
        check({name, " no extra done"}, 64'(dones), 64'd0);
        check({name, " stays idle"}, 64'(busies), 64'd0);
        check({name, " product held"}, bus.product, exp_prod);
    endtask

    initial begin
        logic           sm;
        logic [W-1:0]   m;
        logic [W-1:0]   q;
        logic [2*W-1:0] e;
        n_cmp = 0;
        n_bad = 0;

        vecs[0] = '{1'b1, 32'd7,         32'd2,         64'd14};
        vecs[1] = '{1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFB, 64'd10};
        vecs[2] = '{1'b1, 32'hFFFF_FF01, 32'h0000_0139, 64'hFFFF_FFFF_FFFE_C839};
        vecs[3] = '{1'b1, 32'h0000_0139, 32'hFFFF_FF01, 64'hFFFF_FFFF_FFFE_C839};
        vecs[4] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vecs[5] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1};
        vecs[6] = '{1'b1, 32'hF000_00F5, 32'd0,         64'd0};
        vecs[7] = '{1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000};
        vecs[8] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        vecs[9] = '{1'b0, 32'd0,         32'hFFFF_FFFF, 64'd0};

        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.signed_mode = 1'b0;
        bus.in_m        = '0;
        bus.in_q        = '0;
        repeat (3) @(negedge clk);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset product", bus.product, 64'd0);
        check("reset state", 64'(state_dbg), 64'(IDLE));
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].sm, vecs[i].m, vecs[i].q, vecs[i].exp, -1, $sformatf("vec%0d", i));
            check_quiet(2, $sformatf("vec%0d", i), vecs[i].exp);
        end

        // Back-to-back: second start lands in the done cycle of the first.
        run_op(1'b1, 32'd7, 32'd2, 64'd14, -1, "b2b first");
        run_op(1'b0, 32'd100, 32'd200, 64'd20000, -1, "b2b second");
        check_quiet(2, "b2b", 64'd20000);

        // A start five cycles in must neither disturb nor queue behind the running op.
        run_op(1'b1, 32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6, 5, "restart");
        check_quiet(25, "restart", 64'hFFFF_FFFF_FFFF_FFD6);

        // Abort at cycle 8 of an operation.
        bus.start       = 1'b1;
        bus.signed_mode = 1'b0;
        bus.in_m        = 32'd12345;
        bus.in_q        = 32'd678;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort busy", 64'(bus.busy), 64'd0);
        check("abort done", 64'(bus.done), 64'd0);
        check("abort product", bus.product, 64'd0);
        check("abort state", 64'(state_dbg), 64'(IDLE));
        @(negedge clk);
        reset = 1'b0;
        check_quiet(25, "abort", 64'd0);
        run_op(1'b0, 32'd3, 32'd3, 64'd9, -1, "post abort");
        @(negedge clk);

        for (int i = 0; i < 30; i++) begin
            sm = 1'($urandom_range(0, 1));
            m  = pick_operand();
            q  = pick_operand();
            e  = ref_mult(sm, m, q);
            run_op(sm, m, q, e, -1, $sformatf("rand%0d sm=%0d m=%h q=%h", i, sm, m, q));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
